// File: rtl/fetch_unit_von.sv
// fetch_unit_von: instruction fetch sequencer (IDLE/REQ/VALID/HALT) driving an external PC.
// Define FETCH_TIMEOUT_EN to add a REQ wait timeout (WAIT_MAX cycles) that raises fetch_err and halts.
module fetch_unit_von #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       run,
   input  logic [7:0] pc_value,
   output logic       pc_load,
   output logic [7:0] pc_data,
   output logic       pc_inc,
   output logic       pc_clear,
   output logic       mem_rd,
   output logic [7:0] mem_addr,
   input  logic       mem_ready,
   input  logic [7:0] mem_data,
   output logic [7:0] instr,
   output logic       instr_valid,
   input  logic       instr_ack,
   input  logic       branch_req,
   input  logic [7:0] branch_target,
   input  logic       halt,
   output logic       halted,
   output logic       fetch_err
);
   typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;
   state_t     r_state;
   logic [7:0] r_instr;
   logic       w_ack;
   logic       w_timeout;
   assign w_ack       = (r_state == VALID) && instr_ack && !clear;
   assign mem_rd      = r_state == REQ;
   assign mem_addr    = mem_rd ? pc_value : 8'h00;
   assign pc_inc      = mem_rd && mem_ready && !clear;
   assign pc_load     = w_ack && branch_req;
   assign pc_data     = pc_load ? branch_target : 8'h00;
   assign pc_clear    = clear;
   assign instr       = r_instr;
   assign instr_valid = r_state == VALID;
   assign halted      = r_state == HALT;
`ifdef FETCH_TIMEOUT_EN
   logic [3:0] r_wait;
   logic       r_err;
   assign w_timeout = mem_rd && !mem_ready && (r_wait + 4'd1 == 4'(WAIT_MAX));
   assign fetch_err = r_err;
   // counter is zero outside REQ, so it is already reloaded on every entry
   always_ff @(posedge clk)
      if (clear) begin
         r_wait <= 4'd0;
         r_err  <= 1'b0;
      end else begin
         r_wait <= (mem_rd && !mem_ready) ? r_wait + 4'd1 : 4'd0;
         r_err  <= r_err | w_timeout;
      end
`else
   assign w_timeout = 1'b0;
   // constant 0; WAIT_MAX only matters with the timeout built in
   assign fetch_err = WAIT_MAX < 0;
`endif
   always_ff @(posedge clk)
      if (clear) begin
         r_state <= IDLE;
         r_instr <= 8'h00;
      end else
         case (r_state)
            IDLE:  r_state <= run ? REQ : IDLE;
            REQ:
               if (mem_ready) begin
                  r_instr <= mem_data;
                  r_state <= VALID;
               end else if (w_timeout)
                  r_state <= HALT;
            VALID: if (instr_ack) r_state <= halt ? HALT : run ? REQ : IDLE;
            default: r_state <= HALT;
         endcase
endmodule
